// File: rtl/gravity_sequencer.sv
// gravity_sequencer: frame strobe and pair/axis micro-step sweep sequencer for the three-body datapath
module gravity_sequencer #(
  parameter int NUM_PAIRS   = 6,
  parameter int DIV_W       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             blanking,
  input  logic             run,
  input  logic             step_btn,
  input  logic             restart_btn,
  input  logic [DIV_W-1:0] speed,
  output logic             load_init,
  output logic             pos_update,
  output logic             step_en,
  output logic [2:0]       rel,
  output logic             axis,
  output logic [1:0]       p_idx,
  output logic [1:0]       q_idx,
  output logic             busy,
  output logic             overrun
);
  localparam int CW = (1 << DIV_W) - 1;
  typedef enum logic [1:0] {IDLE, POS, SWEEP} state_t;
  state_t state, state_d;
  logic [SYNC_STAGES-1:0] run_q, step_q, rst_q;
  logic step_prev, rst_prev, latch;
  logic [DIV_W-1:0] spd_q;
  logic [CW-1:0] div_cnt, div_d, div_max;
  logic [2:0] rel_d;
  logic axis_d, run_s, step_edge, restart_edge, active, eligible, last_step;
  assign run_s        = run_q[SYNC_STAGES-1];
  assign step_edge    = step_q[SYNC_STAGES-1] & ~step_prev;
  assign restart_edge = rst_q[SYNC_STAGES-1] & ~rst_prev;
  assign active       = run_s | latch;
  assign eligible     = frame_tick & active & (div_cnt == '0);
  assign last_step    = (rel == 3'(NUM_PAIRS - 1)) & axis;
  // A new period starts at count 0, which is where a speed change is picked up
  assign div_max = CW'((1 << spd_q) - 1);
  assign div_d   = (div_cnt == '0) ? ((speed == '0) ? '0 : CW'(1))
                 : (div_cnt == div_max) ? '0 : div_cnt + CW'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      run_q      <= '0;
      step_q     <= '0;
      rst_q      <= '0;
      step_prev  <= 1'b0;
      rst_prev   <= 1'b0;
      latch      <= 1'b0;
      spd_q      <= '0;
      div_cnt    <= '0;
      rel        <= '0;
      axis       <= 1'b0;
      p_idx      <= '0;
      q_idx      <= '0;
      busy       <= 1'b0;
      load_init  <= 1'b0;
      pos_update <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      run_q      <= {run_q[SYNC_STAGES-2:0], run};
      step_q     <= {step_q[SYNC_STAGES-2:0], step_btn};
      rst_q      <= {rst_q[SYNC_STAGES-2:0], restart_btn};
      step_prev  <= step_q[SYNC_STAGES-1];
      rst_prev   <= rst_q[SYNC_STAGES-1];
      state      <= state_d;
      rel        <= rel_d;
      axis       <= axis_d;
      p_idx      <= rel_d[2:1];
      q_idx      <= (rel_d == 3'd0 || rel_d == 3'd5) ? 2'd1 : (rel_d == 3'd2 || rel_d == 3'd4) ? 2'd0 : 2'd2;
      busy       <= state_d != IDLE;
      load_init  <= restart_edge;
      pos_update <= state_d == POS;
      overrun    <= restart_edge ? 1'b0 : overrun | (state == SWEEP && frame_tick);
      latch      <= (restart_edge || state_d == POS) ? 1'b0 : (step_edge && !run_s) ? 1'b1 : latch;
      div_cnt    <= restart_edge ? '0 : (frame_tick && active) ? div_d : div_cnt;
      spd_q      <= (frame_tick && active && div_cnt == '0) ? speed : spd_q;
    end
  end
  always_comb begin
    state_d = state;
    rel_d   = rel;
    axis_d  = axis;
    if (restart_edge) begin
      state_d = IDLE;
      rel_d   = '0;
      axis_d  = 1'b0;
    end else begin
      unique case (state)
        IDLE:  state_d = eligible ? POS : IDLE;
        POS: begin
          state_d = SWEEP;
          rel_d   = '0;
          axis_d  = 1'b0;
        end
        SWEEP: begin
          if (frame_tick) begin
            state_d = eligible ? POS : IDLE;
            rel_d   = '0;
            axis_d  = 1'b0;
          end else if (blanking) begin
            state_d = last_step ? IDLE : SWEEP;
            rel_d   = last_step ? 3'd0 : axis ? rel + 3'd1 : rel;
            axis_d  = ~axis;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb step_en = (state == SWEEP) && blanking;
endmodule

// File: tb/tb_gravity_sequencer.sv
// tb_gravity_sequencer: directed stimulus with queued expectations checked by a free-running monitor
module tb_gravity_sequencer;
  logic clk = 1'b0, reset = 1'b1, frame_tick = 1'b0, blanking = 1'b1;
  logic run = 1'b0, step_btn = 1'b0, restart_btn = 1'b0;
  logic [1:0] speed = 2'd0;
  logic load_init, pos_update, step_en, axis, busy, overrun;
  logic [2:0] rel;
  logic [1:0] p_idx, q_idx;
  int cyc = 0, n_chk = 0, n_err = 0, n_steps = 0;
  int exp_pos[$], exp_load[$];
  logic [7:0] exp_step[$];

  gravity_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .blanking(blanking), .run(run),
    .step_btn(step_btn), .restart_btn(restart_btn), .speed(speed), .load_init(load_init),
    .pos_update(pos_update), .step_en(step_en), .rel(rel), .axis(axis), .p_idx(p_idx),
    .q_idx(q_idx), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  // Expected sweep order: pair index, axis, accelerated planet, attracting planet
  task automatic push_steps(input int n);
    for (int i = 0; i < n; i++) begin
      int r, q;
      r = i / 2;
      case (r)
        0: q = 1; 1: q = 2; 2: q = 0; 3: q = 2; 4: q = 0; default: q = 1;
      endcase
      exp_step.push_back({3'(r), 1'(i % 2), 2'(r / 2), 2'(q)});
    end
  endtask

  task automatic expect_frame(input int n);
    exp_pos.push_back(cyc + 1);
    push_steps(n);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (step_en) begin
        n_steps++;
        n_chk++;
        if (exp_step.size() == 0) begin
          n_err++;
          $display("FAIL step_extra: got step rel=%0d axis=%0d, required none (cycle %0d)", rel, axis, cyc);
        end else begin
          logic [7:0] e;
          e = exp_step.pop_front();
          if ({rel, axis, p_idx, q_idx} !== e) begin
            n_err++;
            $display("FAIL step_seq: got rel=%0d axis=%0d p=%0d q=%0d, required rel=%0d axis=%0d p=%0d q=%0d",
                     rel, axis, p_idx, q_idx, e[7:5], e[4], e[3:2], e[1:0]);
          end
        end
      end
      if (pos_update) begin
        n_chk++;
        if (exp_pos.size() == 0) begin
          n_err++;
          $display("FAIL pos_extra: got pos_update at cycle %0d, required none", cyc);
        end else begin
          int e;
          e = exp_pos.pop_front();
          if (cyc != e) begin
            n_err++;
            $display("FAIL pos_time: got cycle %0d, required cycle %0d", cyc, e);
          end
        end
      end
      if (load_init) begin
        n_chk++;
        if (exp_load.size() == 0) begin
          n_err++;
          $display("FAIL load_extra: got load_init at cycle %0d, required none", cyc);
        end else begin
          int e;
          e = exp_load.pop_front();
          if (cyc != e) begin
            n_err++;
            $display("FAIL load_time: got cycle %0d, required cycle %0d", cyc, e);
          end
        end
      end
    end
  end

  initial begin
    int s0;
    cycles(3);
    chk("reset_outputs", int'({load_init, pos_update, step_en, rel, axis, p_idx, q_idx, busy, overrun}), 0);
    reset = 1'b0;
    run = 1'b1;
    cycles(5);
    // Free-running, ungated sweep
    s0 = n_steps;
    expect_frame(12);
    tick();
    chk("busy_pos", int'(busy), 1);
    cycles(12);
    chk("busy_last_step", int'(busy), 1);
    cycles(1);
    chk("busy_done", int'(busy), 0);
    chk("steps_plain", n_steps - s0, 12);
    cycles(3);
    // Blanking drops for five cycles mid-sweep
    s0 = n_steps;
    expect_frame(12);
    tick();
    cycles(3);
    blanking = 1'b0;
    cycles(5);
    blanking = 1'b1;
    cycles(9);
    chk("busy_gated_late", int'(busy), 1);
    cycles(1);
    chk("busy_gated_done", int'(busy), 0);
    chk("steps_gated", n_steps - s0, 12);
    cycles(3);
    // Divide by four over eight frames
    speed = 2'd2;
    s0 = n_steps;
    for (int i = 1; i <= 8; i++) begin
      if (i == 1 || i == 5) expect_frame(12);
      tick();
      cycles(19);
    end
    chk("steps_div4", n_steps - s0, 24);
    speed = 2'd0;
    // Paused: only a single-step press yields a frame
    run = 1'b0;
    cycles(4);
    for (int i = 0; i < 4; i++) begin
      tick();
      cycles(5);
    end
    chk("paused_idle", int'(busy), 0);
    step_btn = 1'b1;
    cycles(10);
    step_btn = 1'b0;
    cycles(4);
    s0 = n_steps;
    expect_frame(12);
    tick();
    cycles(19);
    tick();
    cycles(19);
    chk("steps_single", n_steps - s0, 12);
    run = 1'b1;
    cycles(4);
    step_btn = 1'b1;
    cycles(10);
    step_btn = 1'b0;
    cycles(4);
    run = 1'b0;
    cycles(4);
    tick();
    cycles(5);
    chk("step_while_run_ignored", int'(busy), 0);
    run = 1'b1;
    cycles(4);
    // Frame tick lands on step 7 with blanking low: overrun and restart of the sweep
    expect_frame(6);
    tick();
    cycles(7);
    blanking = 1'b0;
    expect_frame(12);
    tick();
    chk("overrun_set", int'(overrun), 1);
    chk("rel_restart", int'({rel, axis}), 0);
    chk("busy_after_abort", int'(busy), 1);
    blanking = 1'b1;
    cycles(14);
    chk("overrun_sticky", int'(overrun), 1);
    chk("busy_after_overrun", int'(busy), 0);
    exp_load.push_back(cyc + 3);
    restart_btn = 1'b1;
    cycles(4);
    chk("overrun_cleared", int'(overrun), 0);
    chk("idle_after_restart", int'(busy), 0);
    restart_btn = 1'b0;
    cycles(4);
    // Restart edge coincides with an eligible frame tick
    exp_load.push_back(cyc + 3);
    restart_btn = 1'b1;
    cycles(2);
    tick();
    chk("restart_beats_tick", int'(busy), 0);
    cycles(3);
    chk("restart_stays_idle", int'(busy), 0);
    restart_btn = 1'b0;
    cycles(4);
    // Reset in the middle of a sweep
    expect_frame(0);
    tick();
    cycles(1);
    push_steps(1);
    cycles(1);
    reset = 1'b1;
    cycles(1);
    chk("reset_mid_sweep", int'({load_init, pos_update, step_en, rel, axis, p_idx, q_idx, busy, overrun}), 0);
    cycles(2);
    chk("pos_queue_empty", exp_pos.size(), 0);
    chk("step_queue_empty", exp_step.size(), 0);
    chk("load_queue_empty", exp_load.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
